// File: rtl/eq_pkg.sv
// eq_pkg: shared types and constants for the biquad cascade equalizer
package eq_pkg;
    localparam int DEF_DATA_W   = 24;
    localparam int DEF_COEF_W   = 18;
    localparam int DEF_FRAC     = 16;
    localparam int DEF_SECTIONS = 4;
    localparam int DEF_CHANNELS = 2;
    localparam int TAPS = 5;
    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    localparam int COEF_PASS = 1 << DEF_FRAC;
    typedef enum logic [2:0] {IDLE, LOAD, MAC, ROUND, OUT} state_t;
    function automatic int pass_coef(input int frac);
        return 1 << frac;
    endfunction
endpackage

// File: rtl/eq_mac.sv
// eq_mac: shared multiply-accumulate with round and limit stage
// EQ_SAT_EN selects clamping (with sat_evt) instead of wrap-around.
module eq_mac
    import eq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat_evt
);
    localparam int PW = DATA_W + COEF_W;
    localparam int ACC_W = PW + 3;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
    logic signed [PW-1:0] prod;
    logic signed [ACC_W-1:0] acc, rnd;
    assign prod = coef * data;
    assign rnd = (acc + HALF) >>> FRAC;
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= sub ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
    end
`ifdef EQ_SAT_EN
    logic hi, lo;
    // out of range when the bits above the sign position disagree with it
    assign hi = !rnd[ACC_W-1] && |rnd[ACC_W-2:DATA_W-1];
    assign lo = rnd[ACC_W-1] && !(&rnd[ACC_W-2:DATA_W-1]);
    assign y = hi ? {1'b0, {(DATA_W-1){1'b1}}} : lo ? {1'b1, {(DATA_W-1){1'b0}}} : rnd[DATA_W-1:0];
    assign sat_evt = hi || lo;
`else
    assign y = rnd[DATA_W-1:0];
    assign sat_evt = 1'b0;
`endif
endmodule

// File: rtl/eq_biquad_cascade.sv
// eq_biquad_cascade: time-multiplexed DF-I biquad cascade over several channels
// EQ_SAT_EN (in eq_mac) enables section output clamping and the sat flag.
module eq_biquad_cascade
    import eq_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int FRAC     = DEF_FRAC,
    parameter int SECTIONS = DEF_SECTIONS,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            din_vld,
    input  logic [CHANNELS*DATA_W-1:0]      din,
    input  logic                            coef_we,
    input  logic [$clog2(SECTIONS*5)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]               coef_wdata,
    output logic                            coef_rdy,
    output logic [CHANNELS*DATA_W-1:0]      dout,
    output logic                            dout_vld,
    output logic                            busy,
    output logic                            drop,
    output logic                            sat
);
    localparam int NC = SECTIONS * TAPS;
    localparam int AW = $clog2(NC);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int SW = SECTIONS > 1 ? $clog2(SECTIONS) : 1;
    state_t state, state_nx;
    logic [2:0] tap;
    logic [SW-1:0] sec;
    logic [CW-1:0] ch, ch_nx;
    logic [AW-1:0] cidx;
    logic last_sec, last_ch, sat_evt;
    logic signed [COEF_W-1:0] coef [NC];
    logic signed [DATA_W-1:0] din_r [CHANNELS];
    logic signed [DATA_W-1:0] res [CHANNELS];
    logic signed [DATA_W-1:0] x1 [CHANNELS][SECTIONS];
    logic signed [DATA_W-1:0] x2 [CHANNELS][SECTIONS];
    logic signed [DATA_W-1:0] y1 [CHANNELS][SECTIONS];
    logic signed [DATA_W-1:0] y2 [CHANNELS][SECTIONS];
    logic signed [DATA_W-1:0] x0, xsel, y;
    assign last_sec = sec == SW'(SECTIONS - 1);
    assign last_ch = ch == CW'(CHANNELS - 1);
    assign ch_nx = last_ch ? '0 : ch + 1'b1;
    assign cidx = AW'(sec * TAPS + tap);
    assign xsel = tap == TAP_B0 ? x0 : tap == TAP_B1 ? x1[ch][sec] : tap == TAP_B2 ? x2[ch][sec] :
                  tap == TAP_A1 ? y1[ch][sec] : y2[ch][sec];
    eq_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC)) u_mac (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .clr(state == LOAD || state == ROUND),
        .en(state == MAC),
        .sub(tap >= TAP_A1),
        .coef(coef[cidx]),
        .data(xsel),
        .y(y),
        .sat_evt(sat_evt)
    );
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        coef_rdy = state == IDLE;
        busy = state != IDLE;
        dout_vld = state == OUT;
        case (state)
            IDLE:    state_nx = din_vld ? LOAD : IDLE;
            LOAD:    state_nx = MAC;
            MAC:     state_nx = tap == TAP_A2 ? ROUND : MAC;
            ROUND:   state_nx = last_sec && last_ch ? OUT : MAC;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < NC; i++) coef[i] <= (i % TAPS == 0) ? COEF_W'(pass_coef(FRAC)) : '0;
        end else if (coef_we && state == IDLE && int'(coef_addr) < NC) begin
            coef[coef_addr] <= coef_wdata;
        end
    end
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tap <= '0;
            sec <= '0;
            ch <= '0;
            x0 <= '0;
            dout <= '0;
            drop <= 1'b0;
            sat <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                din_r[c] <= '0;
                res[c] <= '0;
                for (int s = 0; s < SECTIONS; s++) begin
                    x1[c][s] <= '0;
                    x2[c][s] <= '0;
                    y1[c][s] <= '0;
                    y2[c][s] <= '0;
                end
            end
        end else begin
            if (din_vld && state == IDLE)
                for (int c = 0; c < CHANNELS; c++) din_r[c] <= din[c*DATA_W +: DATA_W];
            if (din_vld && state != IDLE) drop <= 1'b1;
            if (state == ROUND && sat_evt) sat <= 1'b1;
            if (state == LOAD) begin
                tap <= '0;
                sec <= '0;
                ch <= '0;
                x0 <= din_r[0];
            end
            if (state == MAC) tap <= tap + 3'd1;
            if (state == ROUND) begin
                x2[ch][sec] <= x1[ch][sec];
                x1[ch][sec] <= x0;
                y2[ch][sec] <= y1[ch][sec];
                y1[ch][sec] <= y;
                tap <= '0;
                sec <= last_sec ? '0 : sec + 1'b1;
                ch <= last_sec ? ch_nx : ch;
                // the next section consumes this result; a new channel starts from its input
                x0 <= last_sec ? din_r[ch_nx] : y;
                if (last_sec) res[ch] <= y;
                if (last_sec && last_ch)
                    for (int c = 0; c < CHANNELS; c++) dout[c*DATA_W +: DATA_W] <= CW'(c) == ch ? y : res[c];
            end
        end
    end
endmodule

// File: tb/tb_eq_biquad_cascade.sv
// tb_eq_biquad_cascade: directed self-checking bench for the biquad cascade equalizer
module tb_eq_biquad_cascade;
    import eq_pkg::*;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic din_vld = 1'b0;
    logic [47:0] din = '0;
    logic coef_we = 1'b0;
    logic [4:0] coef_addr = '0;
    logic [17:0] coef_wdata = '0;
    logic coef_rdy, dout_vld, busy, drop, sat;
    logic [47:0] dout;
    int n_chk = 0;
    int n_fail = 0;
    int lat, nv, first_rdy, exp_y, exp_sat;
    logic signed [31:0] o0, o1;

    eq_biquad_cascade dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din_vld(din_vld), .din(din),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_rdy(coef_rdy), .dout(dout), .dout_vld(dout_vld), .busy(busy),
        .drop(drop), .sat(sat)
    );

    always #10 sys_clk = ~sys_clk;

    function automatic logic signed [31:0] dch(input int k);
        logic signed [23:0] t;
        t = dout[k*24 +: 24];
        return t;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge sys_clk);
        coef_we = 1'b1;
        coef_addr = 5'(a);
        coef_wdata = 18'(d);
        for (int i = 0; i < 200 && !coef_rdy; i++) @(negedge sys_clk);
        chk("wr_rdy", 32'(coef_rdy), 1);
        @(posedge sys_clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic start(input int d0, input int d1);
        @(negedge sys_clk);
        din = {24'(d1), 24'(d0)};
        din_vld = 1'b1;
        @(posedge sys_clk);
    endtask

    task automatic run(input string tag, input int d0, input int d1, input int e0, input int e1);
        start(d0, d1);
        lat = 0;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(negedge sys_clk);
            din_vld = 1'b0;
            if (dout_vld) lat = n;
        end
        chk({tag, "_lat"}, lat, 50);
        chk({tag, "_ch0"}, dch(0), e0);
        chk({tag, "_ch1"}, dch(1), e1);
        @(negedge sys_clk);
        chk({tag, "_vld_pulse"}, 32'(dout_vld), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
`ifdef EQ_SAT_EN
        exp_y = 8388607;
        exp_sat = 1;
`else
        exp_y = -130;
        exp_sat = 0;
`endif
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 32'(busy), 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("rst_dout", 32'(dout[31:0]), 0);
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_rdy", 32'(coef_rdy), 1);

        run("pass", 1000, -1000, 1000, -1000);

        wr(0, 32768);
        run("gain", 1000, 2000, 500, 1000);

        wr(0, 0);
        wr(1, 65536);
        run("dly_hist", 0, 0, 1000, 2000);
        run("dly_imp", 4096, 0, 0, 0);
        run("dly_next", 0, 0, 4096, 0);
        run("dly_tail", 0, 0, 0, 0);
        chk("sat_before", 32'(sat), 0);

        wr(1, 0);
        wr(0, 131071);
        run("sat", 8388607, 0, exp_y, 0);
        chk("sat_flag", 32'(sat), exp_sat);

        wr(0, COEF_PASS);
        chk("drop_before", 32'(drop), 0);
        start(300, -300);
        lat = 0;
        nv = 0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge sys_clk);
            din_vld = n == 10;
            if (n == 10) din = {24'(777), 24'(777)};
            if (dout_vld) begin
                nv++;
                if (lat == 0) begin
                    lat = n;
                    o0 = dch(0);
                    o1 = dch(1);
                end
            end
        end
        chk("ovr_lat", lat, 50);
        chk("ovr_count", nv, 1);
        chk("ovr_ch0", o0, 300);
        chk("ovr_ch1", o1, -300);
        chk("ovr_drop", 32'(drop), 1);
        chk("ovr_sat_sticky", 32'(sat), exp_sat);

        start(100, 200);
        lat = 0;
        first_rdy = 0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge sys_clk);
            din_vld = 1'b0;
            if (n == 5) begin
                coef_we = 1'b1;
                coef_addr = 5'd0;
                coef_wdata = 18'd32768;
            end
            if (n == 10) chk("bw_rdy_low", 32'(coef_rdy), 0);
            if (dout_vld && lat == 0) begin
                lat = n;
                o0 = dch(0);
                o1 = dch(1);
            end
            if (coef_we && coef_rdy && first_rdy == 0) begin
                first_rdy = n;
                @(posedge sys_clk);
                #1 coef_we = 1'b0;
            end
        end
        chk("bw_lat", lat, 50);
        chk("bw_ch0", o0, 100);
        chk("bw_ch1", o1, 200);
        chk("bw_first_idle", first_rdy, 51);
        run("bw_new", 400, -400, 200, -200);

        chk("mr_drop_before", 32'(drop), 1);
        start(1234, 1234);
        for (int n = 1; n <= 20; n++) begin
            @(negedge sys_clk);
            din_vld = 1'b0;
        end
        chk("mr_busy_mid", 32'(busy), 1);
        sys_rst = 1'b0;
        #1;
        chk("mr_busy_async", 32'(busy), 0);
        chk("mr_rdy_async", 32'(coef_rdy), 1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        nv = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge sys_clk);
            if (dout_vld) nv++;
        end
        chk("mr_no_vld", nv, 0);
        chk("mr_dout0", dch(0), 0);
        chk("mr_dout1", dch(1), 0);
        chk("mr_drop", 32'(drop), 0);
        chk("mr_sat", 32'(sat), 0);
        run("mr_pass", 1000, -1000, 1000, -1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
